// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide unit.
package mdu_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_operand_prep.sv
// Combinational operand conditioning: magnitudes, result sign and special-case flags.
module mdu_operand_prep
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  mdu_op_e          op,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   output logic [XLEN-1:0]  mag_a,
   output logic [XLEN-1:0]  mag_b,
   output logic             neg_res,
   output logic             div_zero,
   output logic             overflow
);

   logic a_signed;
   logic b_signed;
   logic sign_a;
   logic sign_b;

   always_comb begin
      a_signed = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_signed = op inside {OP_MULH, OP_DIV, OP_REM};
      sign_a   = a_signed & a[XLEN-1];
      sign_b   = b_signed & b[XLEN-1];
      mag_a    = sign_a ? -a : a;
      mag_b    = sign_b ? -b : b;
      // remainder follows the dividend; everything else follows the sign product
      neg_res  = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
      div_zero = op[2] && (b == '0);
      overflow = ((op == OP_DIV) || (op == OP_REM)) &&
                 (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide engine with start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for an accepted start
// CALC  | one multiply or divide bit per cycle, counter running down
// DONE  | result valid, done pulses for one cycle
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             funct7_valid,
   input  logic [XLEN-1:0]  bus_rs1,
   input  logic [XLEN-1:0]  bus_rs2,
   output logic             busy,
   output logic             done,
   output logic [XLEN-1:0]  result
);

   mdu_state_e        state;
   mdu_op_e           op_q;
   logic              neg_q;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_nxt;
   logic [XLEN-1:0]   dsr;

   mdu_op_e           op_in;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              neg_res;
   logic              div_zero;
   logic              overflow;
   logic              accept;
   logic [XLEN-1:0]   spec_res;
   logic [XLEN-1:0]   fin_res;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_trial;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   assign op_in  = mdu_op_e'(funct3);
   assign accept = start && (state == IDLE) && (opcode == OPC_OP) &&
                   (funct7 == F7_MULDIV) && funct7_valid;
   assign cnt_nxt = cnt - CNT_W'(1);

   mdu_operand_prep #(.XLEN(XLEN)) u_prep (
      .op       (op_in),
      .a        (bus_rs1),
      .b        (bus_rs2),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .neg_res  (neg_res),
      .div_zero (div_zero),
      .overflow (overflow)
   );

   // acc = {high product / partial remainder, multiplier / dividend-quotient}
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dsr} : '0);
      div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, dsr};
      if (op_q[2]) begin
         if (!div_trial[XLEN])
            acc_nxt = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_nxt = {acc[2*XLEN-2:0], 1'b0};
      end else begin
         acc_nxt = {mul_sum, acc[XLEN-1:1]};
      end
   end

   always_comb begin
      prod = neg_q ? -acc_nxt : acc_nxt;
      quo  = acc_nxt[XLEN-1:0];
      rem  = acc_nxt[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                       fin_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fin_res = neg_q ? -quo : quo;
         default:                      fin_res = neg_q ? -rem : rem;
      endcase
   end

   always_comb begin
      if (div_zero)
         spec_res = funct3[1] ? bus_rs1 : '1;
      else
         spec_res = funct3[1] ? '0 : bus_rs1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         op_q   <= OP_MUL;
         neg_q  <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         dsr    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else if (flush) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  op_q  <= op_in;
                  neg_q <= neg_res;
                  acc   <= {{XLEN{1'b0}}, mag_a};
                  dsr   <= mag_b;
                  cnt   <= CNT_W'(XLEN);
                  busy  <= 1'b1;
                  if (div_zero || overflow) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= spec_res;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt_nxt;
               if (cnt_nxt == '0) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  result <= fin_res;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomised checks of mul_div_unit against a native-arithmetic reference.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        flush;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        funct7_valid;
   logic [31:0] bus_rs1;
   logic [31:0] bus_rs2;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   logic [31:0] sb_res[$];
   int          sb_lat[$];

   mul_div_unit #(.XLEN(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .flush        (flush),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7       (funct7),
      .funct7_valid (funct7_valid),
      .bus_rs1      (bus_rs1),
      .bus_rs2      (bus_rs2),
      .busy         (busy),
      .done         (done),
      .result       (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      logic signed [31:0] sa;
      logic signed [31:0] sbv;
      logic ovf;
      sa  = a;
      sbv = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbv);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && (b == 0)) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic set_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      opcode       = 7'b0110011;
      funct7       = 7'b0000001;
      funct7_valid = 1'b1;
      funct3       = f3;
      bus_rs1      = a;
      bus_rs2      = b;
   endtask

   // interfere: extra start at cycle 5 (busy) and in the DONE cycle, both must be ignored
   task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit interfere);
      int cyc;
      bit busy_ok;
      logic [31:0] exp;
      @(negedge clk);
      set_req(f3, a, b);
      start = 1'b1;
      sb_res.push_back(ref_res(f3, a, b));
      sb_lat.push_back(ref_lat(f3, a, b));
      @(negedge clk);
      start   = 1'b0;
      bus_rs1 = $urandom;
      bus_rs2 = $urandom;
      funct3  = 3'($urandom_range(0, 7));
      cyc     = 1;
      busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         start = interfere && (cyc == 5);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      exp = sb_res.pop_front();
      if (done === 1'b1) begin
         check({tag, "_latency"}, 32'(cyc), 32'(sb_lat.pop_front()));
         check({tag, "_result"}, result, exp);
         check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
         if (interfere) begin
            set_req(3'd0, 32'd3, 32'd3);
            start = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
         check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
         check({tag, "_result_hold"}, result, exp);
      end else begin
         void'(sb_lat.pop_front());
         check({tag, "_done_timeout"}, {31'b0, done}, 32'd1);
      end
      check({tag, "_busy_during"}, {31'b0, busy_ok}, 32'd1);
   endtask

   initial begin
      int seen;
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      set_req(3'd0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_result", result, 32'd0);

      do_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 1'b0);
      do_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 1'b0);
      do_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
      do_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
      do_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         1'b0);
      do_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         1'b0);
      do_op("divu",   3'd5, 32'd7,          32'd2,         1'b0);
      do_op("remu",   3'd7, 32'd7,          32'd2,         1'b0);
      do_op("div0",   3'd4, 32'd5,          32'd0,         1'b0);
      do_op("remu0",  3'd7, 32'd5,          32'd0,         1'b0);
      do_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
      do_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
      do_op("busy_start", 3'd1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
      for (int i = 0; i < 8; i++)
         do_op("rand", 3'(i), $urandom, $urandom, 1'b0);

      // synchronous reset mid-divide
      @(negedge clk);
      set_req(3'd4, 32'd100, 32'd7);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_reset_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", {31'b0, busy}, 32'd0);
      check("midreset_done", {31'b0, done}, 32'd0);
      check("midreset_result", result, 32'd0);

      // flush mid-divide keeps the previous result
      do_op("preflush", 3'd5, 32'd7, 32'd2, 1'b0);
      @(negedge clk);
      set_req(3'd4, 32'hFFFF_FFF9, 32'd2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen++;
         @(negedge clk);
      end
      check("flush_no_done", 32'(seen), 32'd0);
      check("flush_result", result, 32'd3);
      check("flush_busy", {31'b0, busy}, 32'd0);

      // flush beats start in the same IDLE cycle
      set_req(3'd0, 32'd2, 32'd3);
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush_start_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("flush_start_done", {31'b0, done}, 32'd0);

      // non-M opcode and invalid funct7 are ignored
      set_req(3'd0, 32'd2, 32'd3);
      opcode = 7'b0010011;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("badopc_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("badopc_done", {31'b0, done}, 32'd0);
      set_req(3'd4, 32'd0, 32'd0);
      funct7_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("badf7_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("badf7_done", {31'b0, done}, 32'd0);
      check("badf7_result", result, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
